// File: rtl/change_logger_pkg.sv
// change_logger_pkg
// Shared helpers for the multi-channel change logger: memory depth and
// fill-count width derivation from the address length, plus a clog2 helper.
// No ports.
package change_logger_pkg;

    // The fill count must be able to hold DEPTH itself, so it needs one extra bit.
    localparam int COUNT_EXTRA_BITS = 32'sd1;

    // Ceiling log2 for sizing derived from a count of items.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 32'sd0;
        v      = value - 32'sd1;
        while (v > 32'sd0) begin
            result = result + 32'sd1;
            v      = v >>> 1;
        end
        return result;
    endfunction

    // Number of words in a memory addressed by addr_len bits.
    function automatic int depth_of(input int addr_len);
        return 32'sd1 << addr_len;
    endfunction

    // Width of a per-channel fill count that saturates at depth_of(addr_len).
    function automatic int count_width(input int addr_len);
        return addr_len + COUNT_EXTRA_BITS;
    endfunction

endpackage

// File: rtl/CoramMemory1P.sv
// CoramMemory1P
// Behavioural single-port CoRAM memory: synchronous write, registered read
// address, so a word written at an edge is visible on Q after that edge.
// Ports: CLK clock, ADDR address, D write data, WE write enable, Q read data.
module CoramMemory1P #(
    parameter CORAM_THREAD_NAME   = "undefined",
    parameter int CORAM_THREAD_ID = 0,
    parameter int CORAM_ID        = 0,
    parameter int CORAM_SUB_ID    = 0,
    parameter int CORAM_ADDR_LEN  = 10,
    parameter int CORAM_DATA_WIDTH = 32
) (
    input  logic                        CLK,
    input  logic [CORAM_ADDR_LEN-1:0]   ADDR,
    input  logic [CORAM_DATA_WIDTH-1:0] D,
    input  logic                        WE,
    output logic [CORAM_DATA_WIDTH-1:0] Q
);

    localparam int DEPTH = 32'sd1 << CORAM_ADDR_LEN;

    // The identity parameters only matter to the CoRAM toolchain; this marker
    // block merely flags an instance left with the default, unnamed identity.
    localparam int NAME_BITS = $bits(CORAM_THREAD_NAME);
    if (NAME_BITS + CORAM_THREAD_ID + CORAM_ID + CORAM_SUB_ID == 32'sd0) begin : g_unnamed_instance
    end

    logic [CORAM_DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [CORAM_ADDR_LEN-1:0]   rd_addr_q;

    // Array write and read-address register; contents are never reset.
    always_ff @(posedge CLK) begin
        if (WE) begin
            mem_q[ADDR] <= D;
        end
        rd_addr_q <= ADDR;
    end

    assign Q = mem_q[rd_addr_q];

endmodule

// File: rtl/change_logger_channel.sv
// change_logger_channel
// One logging channel: detects changes on in_i, registers one write per
// change into its own CoramMemory1P, tracks write pointer, fill count and
// full/overflow flags, with wrap or drop-when-full behaviour.
// Ports: clk_i, rst_i (async high), enable_i, clear_i (sync), wrap_en_i,
//        in_i sample, out_o memory Q, count_o fill count, full_o, overflow_o.
module change_logger_channel
    import change_logger_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_LEN   = 10,
    parameter int CORAM_ID   = 0,
    parameter THREAD_NAME    = "ctrl_thread"
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             enable_i,
    input  logic                             clear_i,
    input  logic                             wrap_en_i,
    input  logic [DATA_WIDTH-1:0]            in_i,
    output logic [DATA_WIDTH-1:0]            out_o,
    output logic [count_width(ADDR_LEN)-1:0] count_o,
    output logic                             full_o,
    output logic                             overflow_o
);

    localparam int CW = count_width(ADDR_LEN);
    localparam logic [CW-1:0] DEPTH_C = CW'(depth_of(ADDR_LEN));

    logic [DATA_WIDTH-1:0] prev_q, prev_d;
    logic                  primed_q, primed_d;
    logic                  we_q, we_d;
    logic [ADDR_LEN-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [ADDR_LEN-1:0]   wptr_q, wptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  full_q, full_d;
    logic                  ovf_q, ovf_d;
    logic                  event_s;
    logic                  is_full_s;
    logic                  mem_we_s;

    assign event_s   = enable_i && primed_q && (in_i != prev_q);
    assign is_full_s = (count_q == DEPTH_C);
    // A clear in the cycle the write is presented cancels that write.
    assign mem_we_s  = we_q && !clear_i;

    // Next-state: priming, event capture, pointer/count/flag updates.
    always_comb begin
        prev_d   = in_i;
        primed_d = 1'b1;
        we_d     = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        wptr_d   = wptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (clear_i) begin
            primed_d = 1'b0;
            wptr_d   = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end else if (event_s) begin
            if (!is_full_s || wrap_en_i) begin
                we_d   = 1'b1;
                addr_d = wptr_q;
                data_d = in_i;
                wptr_d = wptr_q + ADDR_LEN'(1);
                if (is_full_s) begin
                    // Overwriting the oldest entry; count stays saturated.
                    ovf_d = 1'b1;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end else begin
                // Full and not wrapping: the event is dropped.
                ovf_d = 1'b1;
            end
        end else begin
            we_d = 1'b0;
        end
        full_d = (count_d == DEPTH_C);
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_q   <= '0;
            primed_q <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            wptr_q   <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            prev_q   <= prev_d;
            primed_q <= primed_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            wptr_q   <= wptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            ovf_q    <= ovf_d;
        end
    end

    assign count_o    = count_q;
    assign full_o     = full_q;
    assign overflow_o = ovf_q;

    CoramMemory1P #(
        .CORAM_THREAD_NAME (THREAD_NAME),
        .CORAM_THREAD_ID   (0),
        .CORAM_ID          (CORAM_ID),
        .CORAM_SUB_ID      (0),
        .CORAM_ADDR_LEN    (ADDR_LEN),
        .CORAM_DATA_WIDTH  (DATA_WIDTH)
    ) u_mem (
        .CLK  (clk_i),
        .ADDR (addr_q),
        .D    (data_q),
        .WE   (mem_we_s),
        .Q    (out_o)
    );

endmodule

// File: rtl/change_logger.sv
// change_logger
// NUM_CH independent change-logging channels, each with its own CoRAM
// memory (CORAM_ID = ID_BASE + channel).
// Ports: CLK, RST (async high), ENABLE, CLEAR (sync), WRAP_EN common controls;
//        IN/OUT per-channel DATA_WIDTH slices; COUNT per-channel
//        (ADDR_LEN+1)-bit fill counts; FULL and OVERFLOW per-channel flags.
module change_logger
    import change_logger_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_LEN   = 10,
    parameter int ID_BASE    = 0,
    parameter THREAD_NAME    = "ctrl_thread"
) (
    input  logic                                    CLK,
    input  logic                                    RST,
    input  logic                                    ENABLE,
    input  logic                                    CLEAR,
    input  logic                                    WRAP_EN,
    input  logic [NUM_CH*DATA_WIDTH-1:0]            IN,
    output logic [NUM_CH*DATA_WIDTH-1:0]            OUT,
    output logic [NUM_CH*count_width(ADDR_LEN)-1:0] COUNT,
    output logic [NUM_CH-1:0]                       FULL,
    output logic [NUM_CH-1:0]                       OVERFLOW
);

    localparam int CW = count_width(ADDR_LEN);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        change_logger_channel #(
            .DATA_WIDTH  (DATA_WIDTH),
            .ADDR_LEN    (ADDR_LEN),
            .CORAM_ID    (ID_BASE + c),
            .THREAD_NAME (THREAD_NAME)
        ) u_ch (
            .clk_i      (CLK),
            .rst_i      (RST),
            .enable_i   (ENABLE),
            .clear_i    (CLEAR),
            .wrap_en_i  (WRAP_EN),
            .in_i       (IN[c*DATA_WIDTH +: DATA_WIDTH]),
            .out_o      (OUT[c*DATA_WIDTH +: DATA_WIDTH]),
            .count_o    (COUNT[c*CW +: CW]),
            .full_o     (FULL[c]),
            .overflow_o (OVERFLOW[c])
        );
    end

endmodule

// File: tb/tb_change_logger.sv
// tb_change_logger
// Directed test-plan scenarios followed by randomized traffic, checked
// against a transaction-level model of each channel's log.
module tb_change_logger;

    localparam int NCH   = 3;
    localparam int DW    = 8;
    localparam int AL    = 2;
    localparam int DEPTH = 4;
    localparam int CW    = AL + 1;

    logic                CLK     = 1'b0;
    logic                RST     = 1'b0;
    logic                ENABLE  = 1'b0;
    logic                CLEAR   = 1'b0;
    logic                WRAP_EN = 1'b0;
    logic [NCH*DW-1:0]   IN      = '0;
    logic [NCH*DW-1:0]   OUT;
    logic [NCH*CW-1:0]   COUNT;
    logic [NCH-1:0]      FULL;
    logic [NCH-1:0]      OVERFLOW;

    always #5 CLK = ~CLK;

    change_logger #(
        .NUM_CH      (NCH),
        .DATA_WIDTH  (DW),
        .ADDR_LEN    (AL),
        .ID_BASE     (0),
        .THREAD_NAME ("ctrl_thread")
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .ENABLE   (ENABLE),
        .CLEAR    (CLEAR),
        .WRAP_EN  (WRAP_EN),
        .IN       (IN),
        .OUT      (OUT),
        .COUNT    (COUNT),
        .FULL     (FULL),
        .OVERFLOW (OVERFLOW)
    );

    // Reference model: per channel log contents and bookkeeping.
    int m_mem    [NCH][DEPTH];
    bit m_wr     [NCH][DEPTH];
    int m_prev   [NCH];
    bit m_primed [NCH];
    int m_ptr    [NCH];
    int m_cnt    [NCH];
    bit m_ovf    [NCH];
    bit m_we     [NCH];
    int m_addr   [NCH];
    int m_d      [NCH];
    int m_rd     [NCH];

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic set_in(input int c, input int v);
        IN[c*DW +: DW] = DW'(v);
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_prev[c] = 0; m_primed[c] = 1'b0; m_ptr[c] = 0; m_cnt[c] = 0;
            m_ovf[c] = 1'b0; m_we[c] = 1'b0; m_addr[c] = 0; m_d[c] = 0;
        end
    endtask

    // Applies the rules for one clock edge using the inputs held before it.
    task automatic model_step();
        int inv;
        for (int c = 0; c < NCH; c++) begin
            inv = int'(IN[c*DW +: DW]);
            if (m_we[c] && !CLEAR) begin
                m_mem[c][m_addr[c]] = m_d[c];
                m_wr[c][m_addr[c]]  = 1'b1;
            end
            m_rd[c] = m_addr[c];
            m_we[c] = 1'b0;
            if (CLEAR) begin
                m_primed[c] = 1'b0; m_ptr[c] = 0; m_cnt[c] = 0; m_ovf[c] = 1'b0;
            end else begin
                if (ENABLE && m_primed[c] && inv != m_prev[c]) begin
                    if (m_cnt[c] < DEPTH || WRAP_EN) begin
                        m_we[c]   = 1'b1;
                        m_addr[c] = m_ptr[c];
                        m_d[c]    = inv;
                        m_ptr[c]  = (m_ptr[c] + 1) % DEPTH;
                        if (m_cnt[c] == DEPTH) m_ovf[c] = 1'b1;
                        else m_cnt[c] = m_cnt[c] + 1;
                    end else begin
                        m_ovf[c] = 1'b1;
                    end
                end
                m_primed[c] = 1'b1;
            end
            m_prev[c] = inv;
        end
    endtask

    task automatic check_all();
        for (int c = 0; c < NCH; c++) begin
            check_eq($sformatf("count%0d", c), 32'(COUNT[c*CW +: CW]), 32'(m_cnt[c]));
            check_eq($sformatf("full%0d", c), 32'(FULL[c]), 32'(m_cnt[c] == DEPTH));
            check_eq($sformatf("ovf%0d", c), 32'(OVERFLOW[c]), 32'(m_ovf[c]));
            if (m_rd[c] >= 0 && m_wr[c][m_rd[c]])
                check_eq($sformatf("out%0d", c), 32'(OUT[c*DW +: DW]), 32'(m_mem[c][m_rd[c]]));
        end
    endtask

    task automatic cycle();
        @(posedge CLK);
        model_step();
        #1;
        check_all();
    endtask

    // Called #1 after an edge: asserts reset between edges, holds it over one edge.
    task automatic apply_reset();
        RST = 1'b1;
        #2;
        model_reset();
        check_eq("rst_count", 32'(COUNT), 32'd0);
        check_eq("rst_full", 32'(FULL), 32'd0);
        check_eq("rst_ovf", 32'(OVERFLOW), 32'd0);
        check_all();
        @(posedge CLK);
        for (int c = 0; c < NCH; c++) m_rd[c] = m_addr[c];
        #1;
        check_all();
        RST = 1'b0;
    endtask

    initial begin
        for (int c = 0; c < NCH; c++) begin
            m_rd[c] = -1;
            for (int a = 0; a < DEPTH; a++) begin
                m_wr[c][a] = 1'b0; m_mem[c][a] = 0;
            end
        end
        model_reset();
        #1;
        apply_reset();

        // Single change: write at t+1, OUT at t+2, only channel 0 counts.
        ENABLE = 1'b1; IN = '0; set_in(0, 5);
        cycle();
        set_in(0, 6);
        cycle();
        check_eq("tp1_count0", 32'(COUNT[0 +: CW]), 32'd1);
        check_eq("tp1_count1", 32'(COUNT[CW +: CW]), 32'd0);
        cycle();
        check_eq("tp1_out0", 32'(OUT[0 +: DW]), 32'd6);

        // Back-to-back changes 1,2,3.
        apply_reset();
        IN = '0;
        cycle();
        for (int v = 1; v <= 3; v++) begin set_in(0, v); cycle(); end
        cycle();
        check_eq("tp2_count0", 32'(COUNT[0 +: CW]), 32'd3);
        check_eq("tp2_out0", 32'(OUT[0 +: DW]), 32'd3);

        // Full with drop: fifth change is lost.
        apply_reset();
        WRAP_EN = 1'b0; IN = '0;
        cycle();
        for (int v = 1; v <= 5; v++) begin set_in(0, v); cycle(); end
        cycle();
        check_eq("tp3_count0", 32'(COUNT[0 +: CW]), 32'd4);
        check_eq("tp3_full0", 32'(FULL[0]), 32'd1);
        check_eq("tp3_ovf0", 32'(OVERFLOW[0]), 32'd1);
        check_eq("tp3_out0", 32'(OUT[0 +: DW]), 32'd4);

        // Full with wrap: values 10..15, overflow on the fifth change.
        apply_reset();
        WRAP_EN = 1'b1; IN = '0;
        cycle();
        for (int i = 0; i < 6; i++) begin
            set_in(0, 10 + i);
            cycle();
            if (i == 3) check_eq("tp4_ovf_before", 32'(OVERFLOW[0]), 32'd0);
            if (i == 4) check_eq("tp4_ovf_fifth", 32'(OVERFLOW[0]), 32'd1);
        end
        cycle();
        check_eq("tp4_count0", 32'(COUNT[0 +: CW]), 32'd4);
        check_eq("tp4_out0", 32'(OUT[0 +: DW]), 32'd15);

        // Changes while disabled are never logged; clear cancels a pending write.
        apply_reset();
        WRAP_EN = 1'b0; IN = '0; set_in(0, 7);
        cycle();
        ENABLE = 1'b0; set_in(0, 8);
        cycle();
        ENABLE = 1'b1;
        cycle();
        cycle();
        check_eq("tp5_disabled_count", 32'(COUNT[0 +: CW]), 32'd0);
        set_in(0, 9);
        cycle();
        CLEAR = 1'b1;
        cycle();
        CLEAR = 1'b0;
        check_eq("tp5_clear_count", 32'(COUNT[0 +: CW]), 32'd0);
        set_in(0, 10);
        cycle();
        check_eq("tp5_prime_count", 32'(COUNT[0 +: CW]), 32'd0);
        set_in(0, 11);
        cycle();
        check_eq("tp5_post_count", 32'(COUNT[0 +: CW]), 32'd1);
        cycle();
        check_eq("tp5_post_out", 32'(OUT[0 +: DW]), 32'd11);

        // Reset in the middle of a burst, then priming before logging resumes.
        IN = '0;
        cycle();
        set_in(0, 1); cycle();
        set_in(0, 2); cycle();
        set_in(0, 3);
        apply_reset();
        set_in(0, 4);
        cycle();
        check_eq("tp6_prime_count", 32'(COUNT[0 +: CW]), 32'd0);
        set_in(0, 5);
        cycle();
        check_eq("tp6_post_count", 32'(COUNT[0 +: CW]), 32'd1);

        // Randomized traffic on all channels.
        for (int k = 0; k < 800; k++) begin
            ENABLE = ($urandom_range(0, 9) != 0);
            CLEAR  = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 19) == 0) WRAP_EN = ~WRAP_EN;
            for (int c = 0; c < NCH; c++)
                if ($urandom_range(0, 1) == 1) set_in(c, $urandom_range(0, 3));
            if ($urandom_range(0, 199) == 0) apply_reset();
            else cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/change_logger.md
Name: change_logger

Overview:
- Parametrised multi-channel change logger; the successor of the per-instance single-channel logging leaf.
- Each of NUM_CH channels watches a DATA_WIDTH input and writes every change into its own CoramMemory1P. The CoramMemory1P is owned by control thread THREAD_NAME with CORAM_ID = ID_BASE + channel index.
- Adds over the previous leaf: zero-based addressing, per-channel fill count, full/overflow flags, selectable wrap or stop-when-full mode, enable gating and synchronous clear.
- Sits in userlogic directly; replaces the per-channel SUB wrapper chains.

Parameters:
- NUM_CH, 4, number of independent channels (1..64).
- DATA_WIDTH, 32, bits per channel sample and memory word.
- ADDR_LEN, 10, memory address bits; depth DEPTH = 2**ADDR_LEN.
- ID_BASE, 0, CORAM_ID of channel 0; channel c uses ID_BASE+c.
- THREAD_NAME, "ctrl_thread", CORAM_THREAD_NAME passed to every memory.

Ports:
- CLK  in  1  clock; all logic rising-edge.
- RST  in  1  asynchronous, active-high reset.
- ENABLE  in  1  logging enable, common to all channels.
- CLEAR  in  1  synchronous clear pulse, common to all channels.
- WRAP_EN  in  1  1 = circular overwrite when full, 0 = drop when full.
- IN  in  NUM_CH*DATA_WIDTH  channel c at bits [c*DATA_WIDTH +: DATA_WIDTH].
- OUT  out  NUM_CH*DATA_WIDTH  per-channel memory Q (last logged word).
- COUNT  out  NUM_CH*(ADDR_LEN+1)  per-channel valid-entry count, saturates at DEPTH.
- FULL  out  NUM_CH  COUNT == DEPTH.
- OVERFLOW  out  NUM_CH  sticky: an event was dropped or an entry overwritten.

Behaviour:
- Reset (async, any time): per channel prev=0, primed=0, wptr=0, mem_addr=0, WE=0, d_data=0, COUNT=0, FULL=0, OVERFLOW=0. Memory contents are not reset; OUT is undefined until the first write.
- Priming: in the first cycle after reset or CLEAR, prev<=IN and primed<=1; no event is detected in that cycle.
- prev<=IN every cycle regardless of ENABLE, so changes that occur while disabled are never logged later.
- Event at cycle t: ENABLE && primed && IN_c != prev_c.
- Write at cycle t+1: WE=1, ADDR=wptr, D=IN_c sampled at t. Latency from input change to write is 1 cycle. One write per event; consecutive changes give back-to-back writes.
- After each write: wptr<=wptr+1 mod DEPTH; COUNT<=min(COUNT+1, DEPTH). mem_addr holds the last written address while idle.
- OUT = Q of the synchronous-read memory; the logged value appears on OUT at cycle t+2.
- Full, WRAP_EN=0: the event is dropped (no WE); OVERFLOW<=1; wptr and COUNT unchanged.
- Full, WRAP_EN=1: the write goes to wptr (wrapping 2**ADDR_LEN-1 -> 0); OVERFLOW<=1 on the first overwrite; COUNT stays DEPTH.
- WRAP_EN is sampled at the event cycle t.
- CLEAR (sync) has priority over everything. Next cycle: wptr=0, COUNT=0, FULL=0, OVERFLOW=0, primed=0, WE=0. A write pending from cycle t-1 is cancelled. Memory is not erased.
- CLEAR and an input change in the same cycle: no event logged.
- ENABLE falling: a write already registered (event at t) still completes at t+1.
- Channels are fully independent; there is no shared arbitration.

Decomposition:
- Shared package: function clog2, DEPTH derivation, and COUNT width localparam ADDR_LEN+1.
- Sub-module change_logger_channel contains prev/primed, event detection, write stage, pointer/count/flags and one CoramMemory1P.
- The top is a generate loop over NUM_CH that slices the IN/OUT/COUNT buses.

Test Plan:
- Reset, prime with IN0=5, ENABLE=1, then IN0=6 at t: WE at t+1, ADDR=0, D=6; OUT=6 at t+2; COUNT0=1. Other channels stay at COUNT=0.
- IN0 steps 1,2,3 on consecutive cycles: three back-to-back writes to addresses 0,1,2 with data 1,2,3; COUNT0=3.
- ADDR_LEN=2, WRAP_EN=0, 5 changes: addresses 0..3 written, 5th dropped; FULL0=1, OVERFLOW0=1, COUNT0=4.
- ADDR_LEN=2, WRAP_EN=1, 6 changes (values 10..15): writes 0,1,2,3,0,1; OVERFLOW0 set on the 5th change; COUNT0=4; OUT=15 after the last write.
- ENABLE=0 while IN changes 7->8, then ENABLE=1 with IN held at 8: no writes. CLEAR asserted the cycle after an event: the pending WE is cancelled, COUNT=0, and the next change writes to address 0 only after a priming cycle.
- RST asserted mid-write burst, asynchronously between edges: WE, COUNT, FULL and OVERFLOW drop to 0 immediately; after release the first change is not logged until priming completes.
